mul_seq: RTL

- Multi-cycle signed multiplier in the picoMIPS execute path.
- Consumes the two operands read from the 32 x n register file (Rdata1, Rdata2).
- Produces an n-bit product plus a write request back to the register file.
- Stalls the PC/decoder while running. Sits directly downstream of the register file read ports and feeds its write port through the writeback mux.

---
 rtl/mul_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Multi-cycle signed multiplier for the picoMIPS execute path: unsigned shift-add on
// operand magnitudes, sign applied at the end, with low-half or saturated Q1.(n-1) high-half result.
module mul_seq #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         start,
    input  logic         hi,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [4:0]   dest,
    output logic         stall,
    output logic         done,
    output logic [n-1:0] result,
    output logic         wr,
    output logic [4:0]   waddr
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [2*n-1:0]  acc, mcand, acc_sum, prod;
    logic [n:0]      mplier, abs_a, abs_b;
    logic [n-1:0]    res_nx;
    logic [CW-1:0]   cnt;
    logic            sgn, hi_q, last;

    // Magnitudes are n+1 bits wide so that -2^(n-1) has a representable absolute value.
    assign abs_a   = a[n-1] ? -{a[n-1], a} : {a[n-1], a};
    assign abs_b   = b[n-1] ? -{b[n-1], b} : {b[n-1], b};
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign prod    = sgn ? -acc_sum : acc_sum;
    assign last    = (cnt == CW'(n - 1));

    // Only -2^(n-1) * -2^(n-1) disagrees in the top two bits; clamp it to max positive.
    always_comb begin
        res_nx = prod[n-1:0];
        if (hi_q) begin
            if (prod[2*n-1] ^ prod[2*n-2])
                res_nx = {prod[2*n-1], {(n-1){~prod[2*n-1]}}};
            else
                res_nx = prod[2*n-2:n-1];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign stall = ((state == IDLE) && start) || (state == RUN);
    assign done  = (state == DONE);
    assign wr    = done && (waddr != 5'd0);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            hi_q   <= 1'b0;
            waddr  <= 5'd0;
            result <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    mcand  <= {{(n-1){1'b0}}, abs_a};
                    mplier <= abs_b;
                    sgn    <= a[n-1] ^ b[n-1];
                    hi_q   <= hi;
                    waddr  <= dest;
                    acc    <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) result <= res_nx;
                end
                default: ;
            endcase
        end
    end

endmodule
